tile_sequencer: RTL and testbench
=================================

TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter ROUTER_COUNT, default 8: systolic array height (input router lanes).
REQ-002 SHALL have parameter COLS, default 4: systolic array width (weight columns per tile).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: scratchpad address and size width.
REQ-004 SHALL have parameter TILE_WIDTH, default 4: tile-count width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: i_clk input 1, rising-edge clock; i_nrst input 1, reset.
REQ-006 i_reg_clear  input  1  synchronous clear to IDLE.
REQ-007 i_start  input  1  one-cycle start pulse.
REQ-008 i_num_tiles  input  TILE_WIDTH  output-channel tiles to run.
REQ-009 i_route_size  input  ADDR_WIDTH  pops per tile.
REQ-010 i_w_start_addr, i_w_tile_stride  input  ADDR_WIDTH each  first weight address; per-tile increment.
REQ-011 i_ir_ready, i_wr_ready, i_or_done  input  1 each  router ready flags; output-router completion.
REQ-012 o_ir_en, o_wr_en, o_ir_pop_en, o_wr_pop_en  output  1 each  router enables and pops.
REQ-013 o_w_addr  output  ADDR_WIDTH  current tile weight start address.
REQ-014 o_psum_out_en, o_or_en  output  1 each  array psum shift-out; output-router enable.
REQ-015 o_tile_idx  output  TILE_WIDTH  current tile index.
REQ-016 o_busy, o_done  output  1 each  run active; one-cycle completion pulse.
REQ-017 o_cycle_cnt, o_stall_cnt  output  32 each  performance counters.

Function
REQ-018 States SHALL be IDLE, LOAD, STREAM, DRAIN, FLUSH, OUTPUT, NEXT, DONE.
REQ-019 IDLE->LOAD on i_start with i_num_tiles>0; i_start with i_num_tiles==0 -> DONE directly, no router enable ever asserted.
REQ-020 i_start outside IDLE SHALL be ignored; configuration inputs are captured at the accepted i_start.
REQ-021 LOAD: o_ir_en=o_wr_en=1; -> STREAM when i_ir_ready&&i_wr_ready; captured route size 0 -> DRAIN instead.
REQ-022 STREAM: o_ir_pop_en=o_wr_pop_en=i_ir_ready&&i_wr_ready (combinational, both identical); pop counter increments per pop; after the pop that reaches route size -> DRAIN.
REQ-023 DRAIN: SHALL last exactly ROUTER_COUNT+COLS-1 cycles, then -> FLUSH.
REQ-024 FLUSH: o_psum_out_en=1 for exactly one cycle, -> OUTPUT.
REQ-025 OUTPUT: o_or_en=1 until i_or_done sampled high, -> NEXT; i_or_done outside OUTPUT ignored.
REQ-026 NEXT (one cycle): o_tile_idx+1, o_w_addr+=stride modulo 2^ADDR_WIDTH (wrap, no saturation); -> DONE if last tile else LOAD.
REQ-027 DONE: o_done=1 for one cycle, -> IDLE; o_busy=1 in every state except IDLE.
REQ-028 o_w_addr SHALL equal captured i_w_start_addr from LOAD of tile 0.
REQ-029 i_reg_clear SHALL win over every transition: next cycle IDLE, counters and index zero, all outputs deasserted, no o_done.

Reset
REQ-030 i_nrst low SHALL asynchronously force IDLE, all outputs 0, all counters 0.
REQ-031 Reset mid-run SHALL abandon the run; no o_done on release.

Configuration
REQ-032 Macro TILE_SEQUENCER_PERF_CNT_EN defined: o_cycle_cnt counts o_busy cycles, o_stall_cnt counts STREAM cycles without pop; both clear at accepted i_start, hold after DONE, saturate at all-ones.
REQ-033 Macro undefined: both ports SHALL be constant 0, no counter flops.

Structure
REQ-034 State enum and perf-counter width SHALL live in the shared package accel_pkg.
REQ-035 One sub-module SHALL be natural: seq_drain_counter (load/decrement/zero flag), reused for pop and drain counts.

Verification
REQ-036 ROUTER_COUNT=8, COLS=4, tiles=1, route size=3, readies held 1, i_or_done 2 cycles into OUTPUT -> 3 pops, DRAIN 11 cycles, single psum pulse, o_done once.
REQ-037 tiles=3, start addr 0xF0, stride 0x08 -> o_w_addr 0xF0, 0xF8, 0x00 per tile.
REQ-038 i_wr_ready low 4 cycles mid-STREAM (macro on) -> no pops then, o_stall_cnt=4, total pops = route size.
REQ-039 i_num_tiles=0 -> o_done one cycle after i_start, o_ir_en/o_wr_en never high; route size 0 -> zero pops, DRAIN entered.
REQ-040 i_reg_clear in DRAIN and i_nrst low in OUTPUT -> IDLE, outputs 0, no o_done; a new i_start then runs cleanly.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types for the accelerator tile sequencer: FSM state encoding and perf-counter width.
package accel_pkg;

  localparam int unsigned PERF_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FLUSH  = 3'd4,
    OUTPUT = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } seq_state_e;

  typedef logic [PERF_W-1:0] perf_cnt_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic perf_cnt_t perf_inc(input perf_cnt_t v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/tile_sequencer_if.sv
// Control/status bundle between the tile sequencer (master) and its routers/host (slave).
interface tile_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TILE_WIDTH = 4
);

  logic                          i_reg_clear;
  logic                          i_start;
  logic [TILE_WIDTH-1:0]         i_num_tiles;
  logic [ADDR_WIDTH-1:0]         i_route_size;
  logic [ADDR_WIDTH-1:0]         i_w_start_addr;
  logic [ADDR_WIDTH-1:0]         i_w_tile_stride;
  logic                          i_ir_ready;
  logic                          i_wr_ready;
  logic                          i_or_done;

  logic                          o_ir_en;
  logic                          o_wr_en;
  logic                          o_ir_pop_en;
  logic                          o_wr_pop_en;
  logic [ADDR_WIDTH-1:0]         o_w_addr;
  logic                          o_psum_out_en;
  logic                          o_or_en;
  logic [TILE_WIDTH-1:0]         o_tile_idx;
  logic                          o_busy;
  logic                          o_done;
  logic [accel_pkg::PERF_W-1:0]  o_cycle_cnt;
  logic [accel_pkg::PERF_W-1:0]  o_stall_cnt;

  modport master (
    input  i_reg_clear, i_start, i_num_tiles, i_route_size, i_w_start_addr,
           i_w_tile_stride, i_ir_ready, i_wr_ready, i_or_done,
    output o_ir_en, o_wr_en, o_ir_pop_en, o_wr_pop_en, o_w_addr, o_psum_out_en,
           o_or_en, o_tile_idx, o_busy, o_done, o_cycle_cnt, o_stall_cnt
  );

  modport slave (
    output i_reg_clear, i_start, i_num_tiles, i_route_size, i_w_start_addr,
           i_w_tile_stride, i_ir_ready, i_wr_ready, i_or_done,
    input  o_ir_en, o_wr_en, o_ir_pop_en, o_wr_pop_en, o_w_addr, o_psum_out_en,
           o_or_en, o_tile_idx, o_busy, o_done, o_cycle_cnt, o_stall_cnt
  );

endinterface

// File: rtl/seq_drain_counter.sv
// Loadable down-counter with zero flag; shared by the pop and drain phases of the sequencer.
module seq_drain_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Clear beats load beats decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/tile_sequencer.sv
// Sequences output-channel tiles through load/stream/drain/flush/output on a systolic array.
// Optional perf counters are built only when TILE_SEQUENCER_PERF_CNT_EN is defined.
module tile_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned ROUTER_COUNT = 8,
  parameter int unsigned COLS         = 4,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned TILE_WIDTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  tile_sequencer_if.master  bus
);

  localparam int unsigned DRAIN_CYC = ROUTER_COUNT + COLS - 1;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam int unsigned CNT_W     = (ADDR_WIDTH > DRAIN_W) ? ADDR_WIDTH : DRAIN_W;

  seq_state_e             state;
  seq_state_e             state_nxt;

  logic [TILE_WIDTH-1:0]  num_tiles_q;
  logic [ADDR_WIDTH-1:0]  route_size_q;
  logic [ADDR_WIDTH-1:0]  stride_q;

  logic                   both_ready_c;
  logic                   pop_c;
  logic                   start_ok_c;
  logic                   last_tile_c;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  assign both_ready_c = bus.i_ir_ready & bus.i_wr_ready;
  assign pop_c        = (state == STREAM) & both_ready_c;
  assign start_ok_c   = (state == IDLE) & bus.i_start & ~bus.i_reg_clear;
  assign last_tile_c  = (bus.o_tile_idx == (num_tiles_q - TILE_WIDTH'(1)));

  // Both routers pop together, straight off the ready handshake.
  assign bus.o_ir_pop_en = pop_c;
  assign bus.o_wr_pop_en = pop_c;

  // One counter serves both phases: pops remaining in STREAM, cycles remaining in DRAIN.
  seq_drain_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .clr      (bus.i_reg_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero)
  );

  // Next-state and counter control.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_nxt = (bus.i_num_tiles == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (route_size_q == '0) begin
          state_nxt = DRAIN;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(DRAIN_CYC - 1);
        end else if (both_ready_c) begin
          state_nxt = STREAM;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(route_size_q) - CNT_W'(1);
        end
      end
      STREAM: begin
        if (pop_c) begin
          if (cnt_zero) begin
            state_nxt = DRAIN;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(DRAIN_CYC - 1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_nxt = FLUSH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FLUSH:   state_nxt = OUTPUT;
      OUTPUT: begin
        if (bus.i_or_done) begin
          state_nxt = NEXT;
        end
      end
      NEXT:    state_nxt = last_tile_c ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.i_reg_clear) begin
      state_nxt = IDLE;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
    end
  end

  // State, configuration capture and registered outputs decoded from the next state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state             <= IDLE;
      num_tiles_q       <= '0;
      route_size_q      <= '0;
      stride_q          <= '0;
      bus.o_ir_en       <= 1'b0;
      bus.o_wr_en       <= 1'b0;
      bus.o_psum_out_en <= 1'b0;
      bus.o_or_en       <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_w_addr      <= '0;
      bus.o_tile_idx    <= '0;
    end else begin
      state             <= state_nxt;
      bus.o_ir_en       <= (state_nxt == LOAD);
      bus.o_wr_en       <= (state_nxt == LOAD);
      bus.o_psum_out_en <= (state_nxt == FLUSH);
      bus.o_or_en       <= (state_nxt == OUTPUT);
      bus.o_busy        <= (state_nxt != IDLE);
      bus.o_done        <= (state_nxt == DONE);
      if (bus.i_reg_clear) begin
        bus.o_w_addr   <= '0;
        bus.o_tile_idx <= '0;
      end else if (start_ok_c) begin
        num_tiles_q    <= bus.i_num_tiles;
        route_size_q   <= bus.i_route_size;
        stride_q       <= bus.i_w_tile_stride;
        bus.o_w_addr   <= bus.i_w_start_addr;
        bus.o_tile_idx <= '0;
      end else if (state == NEXT) begin
        bus.o_w_addr   <= bus.o_w_addr + stride_q;
        bus.o_tile_idx <= bus.o_tile_idx + TILE_WIDTH'(1);
      end
    end
  end

`ifdef TILE_SEQUENCER_PERF_CNT_EN
  perf_cnt_t cycle_q;
  perf_cnt_t stall_q;

  // Busy-cycle and stream-stall counters; restart on each accepted start, hold afterwards.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (bus.i_reg_clear || start_ok_c) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (state != IDLE) begin
        cycle_q <= perf_inc(cycle_q);
      end
      if ((state == STREAM) && !both_ready_c) begin
        stall_q <= perf_inc(stall_q);
      end
    end
  end

  assign bus.o_cycle_cnt = cycle_q;
  assign bus.o_stall_cnt = stall_q;
`else
  assign bus.o_cycle_cnt = '0;
  assign bus.o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: directed table runs, clear/reset corners, and random runs vs a timeline model.
module tb_tile_sequencer;

  localparam int unsigned RC = 8;
  localparam int unsigned CL = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned TW = 4;
  localparam int DRAIN_CYC = RC + CL - 1;
  localparam int MAXC = 512;

  logic clk;
  logic nrst;
  int   errors;
  int   checks;

  tile_sequencer_if #(.ADDR_WIDTH(AW), .TILE_WIDTH(TW)) bus ();

  tile_sequencer #(
    .ROUTER_COUNT (RC),
    .COLS         (CL),
    .ADDR_WIDTH   (AW),
    .TILE_WIDTH   (TW)
  ) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tiles;
    logic [7:0] route;
    logic [7:0] start;
    logic [7:0] stride;
    int         stall_at;
    int         stall_len;
    int         pops;
    int         psum;
    int         busy;
    int         stall;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
  } dir_t;

  dir_t tbl [6];

  bit         rir  [MAXC];
  bit         rwr  [MAXC];
  bit         rod  [MAXC];
  bit         chk  [MAXC];
  logic [7:0] expv [MAXC];
  logic [7:0] ea   [MAXC];
  logic [3:0] ei   [MAXC];

  // {ir_en, wr_en, ir_pop, wr_pop, psum, or_en, busy, done}
  function automatic logic [7:0] outv();
    return {bus.o_ir_en, bus.o_wr_en, bus.o_ir_pop_en, bus.o_wr_pop_en,
            bus.o_psum_out_en, bus.o_or_en, bus.o_busy, bus.o_done};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_reg_clear     = 1'b0;
    bus.i_start         = 1'b0;
    bus.i_num_tiles     = '0;
    bus.i_route_size    = '0;
    bus.i_w_start_addr  = '0;
    bus.i_w_tile_stride = '0;
    bus.i_ir_ready      = 1'b0;
    bus.i_wr_ready      = 1'b0;
    bus.i_or_done       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " outs"}, 32'(outv()), 32'd0);
    check({tag, " w_addr"}, 32'(bus.o_w_addr), 32'd0);
    check({tag, " tile_idx"}, 32'(bus.o_tile_idx), 32'd0);
    check({tag, " cycle_cnt"}, bus.o_cycle_cnt, 32'd0);
    check({tag, " stall_cnt"}, bus.o_stall_cnt, 32'd0);
  endtask

  // Watch a window with no start: nothing may become busy or signal done.
  task automatic idle_watch(input int n, input string tag);
    int dones;
    int busy;
    dones = 0;
    busy  = 0;
    for (int c = 0; c < n; c++) begin
      step();
      bus.i_ir_ready = 1'b1;
      bus.i_wr_ready = 1'b1;
      bus.i_or_done  = 1'b1;
      #1;
      if (bus.o_done) dones++;
      if (bus.o_busy) busy++;
    end
    bus.i_or_done = 1'b0;
    check({tag, " no_done"}, 32'(dones), 32'd0);
    check({tag, " no_busy"}, 32'(busy), 32'd0);
  endtask

  // Directed run: readies high except an optional wr stall, or_done in the third OUTPUT cycle.
  task automatic run_dir(input dir_t r, input string tag);
    int pops, psum, dones, busy, drain_bad, drain_last, last_act, done_cyc;
    int stall_left, or_seen, pop_low, pop_diff, ntile;
    bit stalled, fin, drove, prev_ir;
    logic [7:0] addrs [3];
    logic [7:0] exp_a [3];
    pops = 0; psum = 0; dones = 0; busy = 0; drain_bad = 0; drain_last = -1;
    last_act = 0; done_cyc = -1; stall_left = 0; or_seen = 0; pop_low = 0;
    pop_diff = 0; ntile = 0; stalled = 0; fin = 0; prev_ir = 0;
    addrs[0] = '0; addrs[1] = '0; addrs[2] = '0;
    exp_a[0] = r.a0; exp_a[1] = r.a1; exp_a[2] = r.a2;
    step();
    bus.i_start         = 1'b1;
    bus.i_num_tiles     = r.tiles;
    bus.i_route_size    = r.route;
    bus.i_w_start_addr  = r.start;
    bus.i_w_tile_stride = r.stride;
    bus.i_ir_ready      = 1'b1;
    bus.i_wr_ready      = 1'b1;
    bus.i_or_done       = 1'b0;
    #1;
    for (int c = 1; c < 400 && !fin; c++) begin
      step();
      bus.i_start         = 1'b0;
      bus.i_num_tiles     = ~r.tiles;
      bus.i_route_size    = ~r.route;
      bus.i_w_start_addr  = ~r.start;
      bus.i_w_tile_stride = ~r.stride;
      bus.i_wr_ready      = 1'b1;
      if (stall_left > 0) begin
        bus.i_wr_ready = 1'b0;
        stall_left--;
      end
      drove         = (or_seen == 2);
      bus.i_or_done = drove;
      #1;
      if (bus.o_ir_pop_en) begin
        pops++;
        last_act = c;
        if (!bus.i_wr_ready) pop_low++;
      end
      if (bus.o_ir_pop_en != bus.o_wr_pop_en) pop_diff++;
      if (bus.o_ir_en) begin
        last_act = c;
        if (!prev_ir && ntile < 3) begin
          addrs[ntile] = bus.o_w_addr;
          ntile++;
        end
      end
      prev_ir = bus.o_ir_en;
      if (bus.o_psum_out_en) begin
        psum++;
        drain_last = c - last_act - 1;
        if (drain_last != DRAIN_CYC) drain_bad++;
      end
      if (bus.o_or_en) or_seen = drove ? 0 : or_seen + 1;
      if (bus.o_busy) busy++;
      if (bus.o_done) begin
        dones++;
        done_cyc = c;
      end
      if (r.stall_len > 0 && !stalled && pops == r.stall_at) begin
        stalled    = 1'b1;
        stall_left = r.stall_len;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) fin = 1'b1;
    end
    bus.i_or_done = 1'b0;
    check({tag, " finished"}, 32'(fin), 32'd1);
    check({tag, " pops"}, 32'(pops), 32'(r.pops));
    check({tag, " pop_pair"}, 32'(pop_diff), 32'd0);
    check({tag, " pop_while_stalled"}, 32'(pop_low), 32'd0);
    check({tag, " psum_pulses"}, 32'(psum), 32'(r.psum));
    check({tag, " drain_len"}, 32'(drain_bad), 32'd0);
    check({tag, " done_pulses"}, 32'(dones), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(r.busy));
    check({tag, " busy_cycles"}, 32'(busy), 32'(r.busy));
    check({tag, " tiles_loaded"}, 32'(ntile), 32'(r.tiles));
    for (int k = 0; k < 3; k++) begin
      if (k < int'(r.tiles)) check($sformatf("%s w_addr_t%0d", tag, k), 32'(addrs[k]), 32'(exp_a[k]));
    end
    check({tag, " idle_after"}, 32'(outv()), 32'd0);
`ifdef TILE_SEQUENCER_PERF_CNT_EN
    check({tag, " cycle_cnt"}, bus.o_cycle_cnt, 32'(r.busy));
    check({tag, " stall_cnt"}, bus.o_stall_cnt, 32'(r.stall));
`else
    check({tag, " cycle_cnt"}, bus.o_cycle_cnt, 32'd0);
    check({tag, " stall_cnt"}, bus.o_stall_cnt, 32'd0);
`endif
  endtask

  // Random run: open-loop random readies/or_done; expected timeline built from the sequencing rules.
  task automatic run_rand(input int id);
    logic [3:0] tiles;
    logic [7:0] route, sa, st, a;
    int c, endc, stall, n;
    tiles = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
    route = 8'($urandom_range(0, 5));
    sa    = 8'($urandom);
    st    = 8'($urandom);
    for (int i = 0; i < MAXC; i++) begin
      rir[i]  = ($urandom_range(0, 99) < 85);
      rwr[i]  = ($urandom_range(0, 99) < 85);
      rod[i]  = ($urandom_range(0, 99) < 40);
      expv[i] = 8'h00;
      chk[i]  = 1'b0;
      ea[i]   = '0;
      ei[i]   = '0;
    end
    stall = 0;
    c     = 1;
    if (tiles == 4'd0) begin
      expv[1] = 8'b0000_0011;
      endc    = 1;
    end else begin
      for (int k = 0; k < int'(tiles); k++) begin
        a = 8'(int'(sa) + k * int'(st));
        while (c < MAXC - 40) begin
          expv[c] = 8'b1100_0010;
          chk[c]  = 1'b1;
          ea[c]   = a;
          ei[c]   = 4'(k);
          c++;
          if (route == 8'd0 || (rir[c-1] && rwr[c-1])) break;
        end
        n = 0;
        while (n < int'(route) && c < MAXC - 40) begin
          if (rir[c] && rwr[c]) begin
            expv[c] = 8'b0011_0010;
            n++;
          end else begin
            expv[c] = 8'b0000_0010;
            stall++;
          end
          c++;
        end
        for (int d = 0; d < DRAIN_CYC; d++) begin
          expv[c] = 8'b0000_0010;
          c++;
        end
        expv[c] = 8'b0000_1010;
        c++;
        while (c < MAXC - 20) begin
          expv[c] = 8'b0000_0110;
          c++;
          if (rod[c-1]) break;
        end
        expv[c] = 8'b0000_0010;
        c++;
      end
      expv[c] = 8'b0000_0011;
      endc    = c;
    end
    for (int cc = 0; cc <= endc + 2; cc++) begin
      step();
      bus.i_start = (cc == 0) || (cc <= endc && $urandom_range(0, 19) == 0);
      if (cc == 0) begin
        bus.i_num_tiles     = tiles;
        bus.i_route_size    = route;
        bus.i_w_start_addr  = sa;
        bus.i_w_tile_stride = st;
      end else begin
        bus.i_num_tiles     = 4'($urandom);
        bus.i_route_size    = 8'($urandom);
        bus.i_w_start_addr  = 8'($urandom);
        bus.i_w_tile_stride = 8'($urandom);
      end
      bus.i_ir_ready = rir[cc];
      bus.i_wr_ready = rwr[cc];
      bus.i_or_done  = rod[cc];
      #1;
      check($sformatf("rand%0d c%0d outs", id, cc), 32'(outv()), 32'(expv[cc]));
      if (chk[cc]) begin
        check($sformatf("rand%0d c%0d w_addr", id, cc), 32'(bus.o_w_addr), 32'(ea[cc]));
        check($sformatf("rand%0d c%0d tile_idx", id, cc), 32'(bus.o_tile_idx), 32'(ei[cc]));
      end
    end
`ifdef TILE_SEQUENCER_PERF_CNT_EN
    check($sformatf("rand%0d cycle_cnt", id), bus.o_cycle_cnt, 32'(endc));
    check($sformatf("rand%0d stall_cnt", id), bus.o_stall_cnt, 32'(stall));
`else
    check($sformatf("rand%0d cycle_cnt", id), bus.o_cycle_cnt, 32'd0);
    check($sformatf("rand%0d stall_cnt", id), bus.o_stall_cnt, 32'd0);
`endif
    drive_idle();
  endtask

  initial begin
    bit found;
    errors = 0;
    checks = 0;
    //         tiles  route  start  stride st_at st_len pops psum busy stall a0     a1     a2
    tbl[0] = '{4'd1, 8'd3, 8'h10, 8'h04, 0, 0, 3, 1, 21, 0, 8'h10, 8'h00, 8'h00};
    tbl[1] = '{4'd3, 8'd2, 8'hF0, 8'h08, 0, 0, 6, 3, 58, 0, 8'hF0, 8'hF8, 8'h00};
    tbl[2] = '{4'd0, 8'd3, 8'h20, 8'h01, 0, 0, 0, 0, 1,  0, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{4'd1, 8'd0, 8'h30, 8'h02, 0, 0, 0, 1, 18, 0, 8'h30, 8'h00, 8'h00};
    tbl[4] = '{4'd2, 8'd1, 8'h00, 8'hFF, 0, 0, 2, 2, 37, 0, 8'h00, 8'hFF, 8'h00};
    tbl[5] = '{4'd1, 8'd6, 8'h40, 8'h10, 2, 4, 6, 1, 28, 4, 8'h40, 8'h00, 8'h00};

    nrst = 1'b0;
    drive_idle();
    repeat (3) step();
    check_quiet("reset");
    @(negedge clk) nrst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_dir(tbl[i], $sformatf("dir%0d", i));
      drive_idle();
      repeat (2) step();
    end

    // Clear while draining.
    step();
    bus.i_start = 1'b1; bus.i_num_tiles = 4'd1; bus.i_route_size = 8'd1;
    bus.i_w_start_addr = 8'h77; bus.i_w_tile_stride = 8'h01;
    bus.i_ir_ready = 1'b1; bus.i_wr_ready = 1'b1;
    found = 1'b0;
    for (int c = 1; c < 40 && !found; c++) begin
      step();
      bus.i_start = 1'b0;
      #1;
      if (bus.o_ir_pop_en) found = 1'b1;
    end
    check("clr pop_seen", 32'(found), 32'd1);
    repeat (3) step();
    #1;
    check("clr in_drain", 32'(outv()), 32'b0000_0010);
    bus.i_reg_clear = 1'b1;
    step();
    bus.i_reg_clear = 1'b0;
    #1;
    check_quiet("clr after");
    idle_watch(30, "clr");
    drive_idle();
    run_dir(tbl[0], "clr rerun");
    drive_idle();
    repeat (2) step();

    // Asynchronous reset while waiting in OUTPUT.
    step();
    bus.i_start = 1'b1; bus.i_num_tiles = 4'd2; bus.i_route_size = 8'd2;
    bus.i_w_start_addr = 8'h55; bus.i_w_tile_stride = 8'h03;
    bus.i_ir_ready = 1'b1; bus.i_wr_ready = 1'b1; bus.i_or_done = 1'b0;
    found = 1'b0;
    for (int c = 1; c < 80 && !found; c++) begin
      step();
      bus.i_start = 1'b0;
      #1;
      if (bus.o_or_en) found = 1'b1;
    end
    check("rst or_en_seen", 32'(found), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check_quiet("rst async");
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    idle_watch(30, "rst");
    drive_idle();
    run_dir(tbl[1], "rst rerun");
    drive_idle();
    repeat (2) step();

    for (int i = 0; i < 20; i++) begin
      run_rand(i);
      repeat (2) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
